// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the data-RAM arbiter: RAM access modes,
// FSM states, requester ids and the fixed fetch access width.
package mem_arb_pkg;

   localparam logic [1:0] RAM_NONE  = 2'd0;
   localparam logic [1:0] RAM_READ  = 2'd1;
   localparam logic [1:0] RAM_WRITE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_EX = 1'b1;

   // Fetches are always a 32-bit word access
   localparam logic [2:0] FETCH_MEMWID = 3'b010;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way picker. On a tie the port that was not granted last
// wins; the last-granted pointer is held by the caller.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing the single-port data RAM between fetch (port 0)
// and load/store (port 1). Define ARB_ROUND_ROBIN_EN for round-robin ties.
//
// state    | meaning
// ---------+-------------------------------------------
// S_IDLE   | no access in flight
// S_ACCESS | latched command driven to the RAM
// S_RESP   | response registers valid, rvalid pulsed
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int RAM_SIZE   = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req_i,
   input  logic [RAM_SIZE-1:0]   if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   input  logic                  ex_req_i,
   input  logic                  ex_we_i,
   input  logic [RAM_SIZE-1:0]   ex_addr_i,
   input  logic [DATA_WIDTH-1:0] ex_wdata_i,
   input  logic [2:0]            ex_memwid_i,
   output logic                  ex_gnt_o,
   output logic                  ex_rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o,
   output logic [RAM_SIZE-1:0]   ram_addr_o,
   output logic [1:0]            ram_mode_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   output logic [2:0]            ram_memwid_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i,
   input  logic                  ram_err_i
);

   state_t                state_q, state_d;
   logic [1:0]            req, pick, gnt;
   logic                  grant;
   logic                  last_q;
   logic                  port_q;
   logic                  we_q;
   logic [RAM_SIZE-1:0]   addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [2:0]            memwid_q;

   assign req = {ex_req_i, if_req_i};

   rr_arb2 u_rr_arb2 (
      .req  (req),
      .last (last_q),
      .gnt  (pick)
   );

   // No grant while the RAM is busy, and none while reset is held
   always_comb begin
      gnt = 2'b00;
      if (rst_n && (state_q != S_ACCESS)) gnt = pick;
   end

   assign grant    = |gnt;
   assign if_gnt_o = gnt[0];
   assign ex_gnt_o = gnt[1];

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     last_q <= PORT_IF;
      else if (grant) last_q <= gnt[1];
   end
`else
   assign last_q = PORT_IF;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (grant) state_d = S_ACCESS;
         S_ACCESS: state_d = S_RESP;
         S_RESP:   state_d = grant ? S_ACCESS : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         port_q   <= PORT_IF;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         memwid_q <= '0;
         rdata_o  <= '0;
         err_o    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            port_q   <= gnt[1];
            we_q     <= gnt[1] & ex_we_i;
            addr_q   <= gnt[1] ? ex_addr_i : if_addr_i;
            wdata_q  <= gnt[1] ? ex_wdata_i : '0;
            memwid_q <= gnt[1] ? ex_memwid_i : FETCH_MEMWID;
         end
         if (state_q == S_ACCESS) begin
            rdata_o <= ram_rdata_i;
            err_o   <= ram_err_i;
         end
      end
   end

   always_comb begin
      ram_mode_o   = RAM_NONE;
      ram_addr_o   = '0;
      ram_wdata_o  = '0;
      ram_memwid_o = '0;
      if (state_q == S_ACCESS) begin
         ram_mode_o   = we_q ? RAM_WRITE : RAM_READ;
         ram_addr_o   = addr_q;
         ram_wdata_o  = wdata_q;
         ram_memwid_o = memwid_q;
      end
   end

   assign if_rvalid_o = (state_q == S_RESP) && (port_q == PORT_IF);
   assign ex_rvalid_o = (state_q == S_RESP) && (port_q == PORT_EX);

endmodule
